// File: rtl/palette_ram_if.sv
// Lookup, write, restore and cycling signals of the palette RAM.
// The pixel pipeline side is the master; palette_ram is the slave.
interface palette_ram_if #(
  parameter int CID_W   = 3,
  parameter int PID_W   = 2,
  parameter int COLOR_W = 6
);
  // Lookup path
  logic [CID_W-1:0]   cid;
  logic [PID_W-1:0]   pid;
  logic               blank;
  logic [COLOR_W-1:0] color;
  // Runtime single-entry write
  logic               wr_en;
  logic [PID_W-1:0]   wr_pid;
  logic [CID_W-1:0]   wr_cid;
  logic [COLOR_W-1:0] wr_data;
  // Default-table restore
  logic               load_defaults;
  logic               busy;
  // Colour cycling
  logic               cycle_en;
  logic               frame_tick;
  logic [CID_W-1:0]   cycle_offset;

  modport master (
    output cid, pid, blank,
    output wr_en, wr_pid, wr_cid, wr_data,
    output load_defaults,
    output cycle_en, frame_tick,
    input  color, busy, cycle_offset
  );

  modport slave (
    input  cid, pid, blank,
    input  wr_en, wr_pid, wr_cid, wr_data,
    input  load_defaults,
    input  cycle_en, frame_tick,
    output color, busy, cycle_offset
  );
endinterface

// File: rtl/palette_ram.sv
// Writable palette RAM: P palettes of N colours held in flops, registered
// colour lookup with rotation of entries 1..N-1 (colour cycling), runtime
// single-entry writes and a sequencer that restores the built-in defaults.
module palette_ram #(
  parameter int CID_W     = 3,
  parameter int PID_W     = 2,
  parameter int COLOR_W   = 6,
  parameter int CYCLE_DIV = 8
) (
  input logic          clk,
  input logic          rst_n,
  palette_ram_if.slave bus
);

  localparam int N      = 1 << CID_W;
  localparam int P      = 1 << PID_W;
  localparam int DEPTH  = N * P;
  localparam int IDX_W  = CID_W + PID_W;
  localparam int TICK_W = (CYCLE_DIV > 1) ? $clog2(CYCLE_DIV) : 1;

  localparam logic [CID_W:0]    NM1      = (CID_W+1)'(N - 1);
  localparam logic [CID_W-1:0]  OFF_MAX  = CID_W'(N - 2);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CYCLE_DIV - 1);
  localparam logic [IDX_W-1:0]  PTR_LAST = IDX_W'(DEPTH - 1);

  // Built-in 4x8 table, RRGGBB, index = pid*8 + cid.
  localparam logic [5:0] DEF_TABLE [32] = '{
    6'h00, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h1D, 6'h1E, 6'h2E,
    6'h00, 6'h10, 6'h20, 6'h30, 6'h31, 6'h35, 6'h36, 6'h3A,
    6'h00, 6'h01, 6'h02, 6'h03, 6'h07, 6'h17, 6'h1B, 6'h2B,
    6'h00, 6'h30, 6'h38, 6'h3C, 6'h08, 6'h07, 6'h22, 6'h33
  };

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  // Default colour for a flat {pid,cid} index; entries outside the 4x8
  // table are black, wider colour words are zero-extended.
  function automatic logic [COLOR_W-1:0] default_entry(input logic [IDX_W-1:0] idx);
    logic [PID_W-1:0] p;
    logic [CID_W-1:0] c;
    logic [5:0]       v;
    p = idx[IDX_W-1:CID_W];
    c = idx[CID_W-1:0];
    v = 6'h00;
    if ((32'(p) < 32'd4) && (32'(c) < 32'd8))
      v = DEF_TABLE[5'(32'(p) * 32'd8 + 32'(c))];
    return COLOR_W'(v);
  endfunction

  logic [COLOR_W-1:0] mem_q [DEPTH];
  logic [COLOR_W-1:0] color_q, color_d;
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [CID_W-1:0]   off_q, off_d;

  logic               busy;
  logic [CID_W-1:0]   cid_m1;
  logic [CID_W:0]     rot_sum;
  logic [CID_W-1:0]   phys_cid;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [COLOR_W-1:0] mem_wdata;

  assign busy = (state_q == LOAD);

  // Restore sequencer: next state and pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load_defaults) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == PTR_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Restore sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Single write port: restore has priority, user writes are dropped while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = default_entry(ptr_q);
    end else if (bus.wr_en) begin
      mem_we    = 1'b1;
      mem_waddr = {bus.wr_pid, bus.wr_cid};
      mem_wdata = bus.wr_data;
    end
  end

  // Palette storage.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this storage is flops, not a RAM macro, and reset must bring
    // back the default palettes, so every entry is reset explicitly.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= default_entry(IDX_W'(i));
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Rotated physical index: entry 0 fixed, entries 1..N-1 rotate by off_q.
  always_comb begin
    cid_m1  = bus.cid - CID_W'(1);
    rot_sum = {1'b0, cid_m1} + {1'b0, off_q};
    if (rot_sum >= NM1) rot_sum = rot_sum - NM1;
    phys_cid = (bus.cid == '0) ? '0 : (rot_sum[CID_W-1:0] + CID_W'(1));
    color_d  = bus.blank ? '0 : mem_q[{bus.pid, phys_cid}];
  end

  // Registered lookup result; reads see pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) color_q <= '0;
    else        color_q <= color_d;
  end

  // Cycling divider and rotation offset next state; both hold when disabled.
  always_comb begin
    tick_d = tick_q;
    off_d  = off_q;
    if (bus.cycle_en && bus.frame_tick) begin
      if (tick_q == TICK_MAX) begin
        tick_d = '0;
        off_d  = (off_q == OFF_MAX) ? '0 : (off_q + CID_W'(1));
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  // Cycling divider and rotation offset registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      off_q  <= '0;
    end else begin
      tick_q <= tick_d;
      off_q  <= off_d;
    end
  end

  assign bus.color        = color_q;
  assign bus.busy         = busy;
  assign bus.cycle_offset = off_q;

endmodule

// File: tb/tb_palette_ram.sv
// Directed bench for palette_ram: default-geometry instance plus a
// CID_W=4 / COLOR_W=8 / CYCLE_DIV=1 instance for the parameter checks.
module tb_palette_ram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  palette_ram_if #(.CID_W(3), .PID_W(2), .COLOR_W(6)) bus ();
  palette_ram_if #(.CID_W(4), .PID_W(2), .COLOR_W(8)) bus2 ();

  palette_ram #(.CID_W(3), .PID_W(2), .COLOR_W(6), .CYCLE_DIV(8)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  palette_ram #(.CID_W(4), .PID_W(2), .COLOR_W(8), .CYCLE_DIV(1)) u_dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2.slave)
  );

  localparam logic [5:0] DEF [32] = '{
    6'h00, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h1D, 6'h1E, 6'h2E,
    6'h00, 6'h10, 6'h20, 6'h30, 6'h31, 6'h35, 6'h36, 6'h3A,
    6'h00, 6'h01, 6'h02, 6'h03, 6'h07, 6'h17, 6'h1B, 6'h2B,
    6'h00, 6'h30, 6'h38, 6'h3C, 6'h08, 6'h07, 6'h22, 6'h33
  };

  typedef struct {
    int         pid;
    int         cid;
    logic       blank;
    logic [5:0] exp;
  } vec_t;

  int tests = 0;
  int failed = 0;
  logic [5:0] col;
  logic [7:0] col2;
  int cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input int p, input int c, input logic b, output logic [5:0] res);
    bus.pid   = 2'(p);
    bus.cid   = 3'(c);
    bus.blank = b;
    step();
    res = bus.color;
  endtask

  task automatic write_entry(input int p, input int c, input logic [5:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_pid  = 2'(p);
    bus.wr_cid  = 3'(c);
    bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  // Whole-table readback against the default table (offset must be 0).
  task automatic check_defaults(input string tag);
    logic [5:0] r;
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 8; c++) begin
        lookup(p, c, 1'b0, r);
        check($sformatf("%s p%0d c%0d", tag, p, c), 32'(r), 32'(DEF[p*8+c]));
      end
  endtask

  task automatic tick_pulse();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask

  initial begin
    vec_t vecs [10];
    vecs[0] = '{1, 3, 1'b0, 6'h30};
    vecs[1] = '{1, 3, 1'b1, 6'h00};
    vecs[2] = '{0, 3, 1'b0, 6'h0C};
    vecs[3] = '{2, 7, 1'b0, 6'h2B};
    vecs[4] = '{3, 1, 1'b0, 6'h30};
    vecs[5] = '{3, 6, 1'b0, 6'h22};
    vecs[6] = '{0, 0, 1'b0, 6'h00};
    vecs[7] = '{3, 7, 1'b0, 6'h33};
    vecs[8] = '{2, 4, 1'b1, 6'h00};
    vecs[9] = '{1, 7, 1'b0, 6'h3A};

    bus.cid = '0; bus.pid = '0; bus.blank = 1'b0;
    bus.wr_en = 1'b0; bus.wr_pid = '0; bus.wr_cid = '0; bus.wr_data = '0;
    bus.load_defaults = 1'b0; bus.cycle_en = 1'b0; bus.frame_tick = 1'b0;
    bus2.cid = '0; bus2.pid = '0; bus2.blank = 1'b0;
    bus2.wr_en = 1'b0; bus2.wr_pid = '0; bus2.wr_cid = '0; bus2.wr_data = '0;
    bus2.load_defaults = 1'b0; bus2.cycle_en = 1'b0; bus2.frame_tick = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst color", 32'(bus.color), 32'h0);
    check("rst busy", 32'(bus.busy), 32'h0);
    check("rst offset", 32'(bus.cycle_offset), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table-driven lookups against defaults
    for (int i = 0; i < 10; i++) begin
      lookup(vecs[i].pid, vecs[i].cid, vecs[i].blank, col);
      check($sformatf("vec%0d", i), 32'(col), 32'(vecs[i].exp));
    end

    // Read-during-write returns the old value, new value next cycle
    bus.wr_en = 1'b1; bus.wr_pid = 2'd2; bus.wr_cid = 3'd5; bus.wr_data = 6'h3F;
    bus.pid = 2'd2; bus.cid = 3'd5; bus.blank = 1'b0;
    step();
    bus.wr_en = 1'b0;
    check("rdw old", 32'(bus.color), 32'h17);
    step();
    check("rdw new", 32'(bus.color), 32'h3F);
    lookup(0, 5, 1'b0, col); check("other pal0 c5", 32'(col), 32'h1D);
    lookup(1, 5, 1'b0, col); check("other pal1 c5", 32'(col), 32'h35);
    lookup(3, 5, 1'b0, col); check("other pal3 c5", 32'(col), 32'h07);

    // Restore: write together with load_defaults, wr_en and load_defaults during busy
    write_entry(0, 2, 6'h15);
    lookup(0, 2, 1'b0, col); check("pre-restore wr", 32'(col), 32'h15);
    bus.wr_en = 1'b1; bus.wr_pid = 2'd0; bus.wr_cid = 3'd1; bus.wr_data = 6'h2A;
    bus.load_defaults = 1'b1;
    step();
    bus.load_defaults = 1'b0;
    bus.wr_pid = 2'd3; bus.wr_cid = 3'd2; bus.wr_data = 6'h3F;
    check("busy rise", 32'(bus.busy), 32'h1);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      bus.load_defaults = (cnt == 5);
      step();
    end
    bus.wr_en = 1'b0;
    bus.load_defaults = 1'b0;
    check("busy cycles", 32'(cnt), 32'd32);
    check_defaults("restore");

    // Abort a restore with reset after a non-zero offset
    bus.cycle_en = 1'b1;
    repeat (8) tick_pulse();
    bus.cycle_en = 1'b0;
    check("pre-abort offset", 32'(bus.cycle_offset), 32'h1);
    write_entry(1, 2, 6'h01);
    bus.load_defaults = 1'b1;
    step();
    bus.load_defaults = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'h0);
    check("abort offset", 32'(bus.cycle_offset), 32'h0);
    check("abort color", 32'(bus.color), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_defaults("abort");

    // Cycling: counter holds while disabled
    bus.cycle_en = 1'b1;
    repeat (3) tick_pulse();
    bus.cycle_en = 1'b0;
    repeat (5) tick_pulse();
    check("hold offset", 32'(bus.cycle_offset), 32'h0);
    bus.cycle_en = 1'b1;
    repeat (4) tick_pulse();
    check("7 ticks offset", 32'(bus.cycle_offset), 32'h0);
    // Qualifying tick and lookup on the same edge use the old offset
    bus.frame_tick = 1'b1; bus.pid = 2'd0; bus.cid = 3'd1; bus.blank = 1'b0;
    step();
    bus.frame_tick = 1'b0;
    check("tick edge old off", 32'(bus.color), 32'h04);
    check("offset 1", 32'(bus.cycle_offset), 32'h1);
    lookup(0, 1, 1'b0, col); check("rot c1", 32'(col), 32'h08);
    lookup(0, 7, 1'b0, col); check("rot c7", 32'(col), 32'h04);
    lookup(0, 0, 1'b0, col); check("rot c0", 32'(col), 32'h00);
    for (int k = 2; k <= 7; k++) begin
      repeat (8) tick_pulse();
      check($sformatf("offset step %0d", k), 32'(bus.cycle_offset), (k == 7) ? 32'd0 : 32'(k));
    end
    bus.cycle_en = 1'b0;

    // Wide-parameter instance
    for (int c = 8; c < 16; c++) begin
      bus2.pid = 2'd0; bus2.cid = 4'(c); bus2.blank = 1'b0;
      step();
      col2 = bus2.color;
      check($sformatf("w pal0 c%0d", c), 32'(col2), 32'h0);
    end
    bus2.cid = 4'd3;
    step();
    check("w pal0 c3", 32'(bus2.color), 32'h0C);
    bus2.cycle_en = 1'b1; bus2.frame_tick = 1'b1;
    repeat (14) step();
    check("w offset 14", 32'(bus2.cycle_offset), 32'd14);
    step();
    bus2.frame_tick = 1'b0; bus2.cycle_en = 1'b0;
    check("w offset wrap", 32'(bus2.cycle_offset), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/palette_ram.md
# palette_ram

Writable, parametrised successor to the fixed glyph-mode palette lookup. Holds 2^PID_W palettes of 2^CID_W colours each in flops, returns a registered RRGGBB colour for each (pid, cid) lookup, accepts single-entry runtime writes and supports frame-driven colour cycling. A sequencer can restore the built-in default table. The block sits between the glyph/pixel pipeline and the VGA output register.

## Interface
Parameters:
- CID_W, 3, colour-id width; N = 2^CID_W entries per palette
- PID_W, 2, palette-id width; P = 2^PID_W palettes
- COLOR_W, 6, output colour width (RRGGBB at 6)
- CYCLE_DIV, 8, frame_tick pulses per cycling step (≥1)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- cid  in  CID_W  lookup colour id
- pid  in  PID_W  lookup palette id
- blank  in  1  force output colour to 0
- color  out  COLOR_W  registered lookup result
- wr_en  in  1  write strobe, one entry per cycle
- wr_pid  in  PID_W  write palette
- wr_cid  in  CID_W  write colour id (physical index, not rotated)
- wr_data  in  COLOR_W  write value
- load_defaults  in  1  start default-table restore
- busy  out  1  restore in progress
- cycle_en  in  1  enable colour cycling
- frame_tick  in  1  one-cycle pulse per frame
- cycle_offset  out  CID_W  current rotation offset

## Operation
- Default table (hex, cid 0..7): pal0 00,04,08,0C,0D,1D,1E,2E; pal1 00,10,20,30,31,35,36,3A; pal2 00,01,02,03,07,17,1B,2B; pal3 00,30,38,3C,08,07,22,33. Entries outside 4x8 default to 0; wider COLOR_W zero-extends.
- Lookup: physical index e = 0 if cid==0, else 1 + ((cid−1+cycle_offset) mod (N−1)). color <= blank ? 0 : mem[pid][e].
- Entry 0 (background) never rotates.
- Write: wr_en && !busy writes mem[wr_pid][wr_cid] at the clock edge. wr_en while busy is dropped (no queueing).
- Read-during-write to the same entry returns the old value; new value is visible on the next lookup.
- Cycling: tick counter (0..CYCLE_DIV−1) increments on frame_tick while cycle_en. On a tick with counter == CYCLE_DIV−1, the counter clears and cycle_offset advances, wrapping N−2 → 0.
- cycle_en low: counter and cycle_offset hold (no reset).
- Restore FSM:
  - States IDLE and LOAD.
  - IDLE→LOAD on load_defaults: busy=1, pointer=0.
  - LOAD writes one entry per cycle, pointer = {pid,cid} from 0 to P·N−1, then returns to IDLE with busy=0.
  - load_defaults in LOAD is ignored.
  - Lookups continue during LOAD against the current (partly restored) contents.
  - Restore does not change cycle_offset.

## Timing
- Async reset (rst_n low):
  - mem = default table
  - color=0, busy=0, cycle_offset=0
  - tick counter=0, FSM=IDLE
- Reset mid-restore aborts LOAD; contents still return to defaults.
- Lookup latency: 1 cycle (inputs at edge k → color valid after edge k).
- Write latency: 1 cycle.
- busy rises the cycle after load_defaults is sampled and stays high exactly P·N cycles (32 at defaults).
- cycle_offset updates the cycle after the qualifying frame_tick. Lookups on that same edge use the old offset.
- Simultaneous wr_en and load_defaults in IDLE: the write is performed, then LOAD starts and overwrites that entry.

## Test plan
- Reset, pid=1, cid=3, blank=0 → color=0x30 one cycle later; blank=1 → 0x00.
- Write pid=2, cid=5, 0x3F, with a lookup of the same entry on the same cycle → 0x17, then next cycle 0x3F; cid=5 in other palettes is unchanged.
- cycle_en=1, 8 frame_ticks → cycle_offset=1; pid=0, cid=1 → 0x08; cid=7 → 0x04; cid=0 → 0x00; after 48 more ticks offset wraps 6→0.
- Write entries, pulse load_defaults → busy high 32 cycles; wr_en during busy is ignored; table matches defaults afterwards.
- Assert rst_n low at pointer 10 of a restore → busy=0 immediately, table equals defaults, cycle_offset=0.
- Parameter build CID_W=4, COLOR_W=8 → pal0 cid 8..15 read 0; cid 3 reads 0x0C; offset wraps at 14.
